// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the FD/DX/XM pipeline latches: load-use stalls, branch flushes
// and multi-cycle mul/div sequencing. Define PIPE_HAZARD_STALL_CNT_EN to add the stallCnt output.
module pipe_hazard_ctrl #(
    parameter int MD_MAX_CYCLES = 40
`ifdef PIPE_HAZARD_STALL_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] fdInstr,
    input  logic [31:0] dxInstr,
    input  logic        brTaken,
    input  logic        mdReady,
    output logic        pcEnable,
    output logic        fdEnable,
    output logic        fdClear,
    output logic        dxEnable,
    output logic        dxClear,
    output logic        xmClear,
    output logic        mdStart,
    output logic        mdError
`ifdef PIPE_HAZARD_STALL_CNT_EN
    , output logic [CNT_W-1:0] stallCnt
`endif
);

    localparam int MD_CNT_W = ($clog2(MD_MAX_CYCLES) > 6) ? $clog2(MD_MAX_CYCLES) : 6;
    localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_MAX_CYCLES - 1);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic {
        IDLE,
        MD_BUSY
    } state_t;

    state_t                state_q, state_d;
    logic [MD_CNT_W-1:0]   md_cnt_q, md_cnt_d;

    logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
    logic [4:0] dx_op, dx_rd, dx_aluop;
    logic       fd_uses_rs, fd_uses_rt, fd_uses_rd;
    logic       load_use, dx_is_md;
    logic       unused_bits;

    assign fd_op    = fdInstr[31:27];
    assign fd_rd    = fdInstr[26:22];
    assign fd_rs    = fdInstr[21:17];
    assign fd_rt    = fdInstr[16:12];
    assign dx_op    = dxInstr[31:27];
    assign dx_rd    = dxInstr[26:22];
    assign dx_aluop = dxInstr[6:2];
    assign unused_bits = ^{fdInstr[11:0], dxInstr[21:7], dxInstr[1:0]};

    // Which register fields the decode-stage instruction actually reads; r0 never hazards.
    always_comb begin
        fd_uses_rs = !(fd_op inside {OP_J, OP_JAL, OP_SETX, OP_BEX});
        fd_uses_rt = (fd_op == OP_RTYPE);
        fd_uses_rd = (fd_op inside {OP_SW, OP_BNE, OP_BLT, OP_JR});
        load_use   = (dx_op == OP_LW) && (dx_rd != 5'd0) &&
                     ((fd_uses_rs && (fd_rs == dx_rd)) ||
                      (fd_uses_rt && (fd_rt == dx_rd)) ||
                      (fd_uses_rd && (fd_rd == dx_rd)));
        dx_is_md   = (dx_op == OP_RTYPE) && ((dx_aluop == ALU_MUL) || (dx_aluop == ALU_DIV));
    end

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        pcEnable = 1'b1;
        fdEnable = 1'b1;
        dxEnable = 1'b1;
        fdClear  = 1'b0;
        dxClear  = 1'b0;
        xmClear  = 1'b0;
        mdStart  = 1'b0;
        mdError  = 1'b0;
        if (clear) begin
            fdClear  = 1'b1;
            dxClear  = 1'b1;
            xmClear  = 1'b1;
            state_d  = IDLE;
            md_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // A taken branch flushes the wrong-path instructions, so it wins over stalls.
                    if (brTaken) begin
                        fdClear = 1'b1;
                        dxClear = 1'b1;
                    end else if (dx_is_md) begin
                        mdStart  = 1'b1;
                        pcEnable = 1'b0;
                        fdEnable = 1'b0;
                        dxEnable = 1'b0;
                        xmClear  = 1'b1;
                        md_cnt_d = '0;
                        state_d  = MD_BUSY;
                    end else if (load_use) begin
                        pcEnable = 1'b0;
                        fdEnable = 1'b0;
                        dxClear  = 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (mdReady) begin
                        md_cnt_d = '0;
                        state_d  = IDLE;
                    end else if (md_cnt_q == MD_LAST) begin
                        mdError  = 1'b1;
                        dxClear  = 1'b1;
                        md_cnt_d = '0;
                        state_d  = IDLE;
                    end else begin
                        pcEnable = 1'b0;
                        fdEnable = 1'b0;
                        dxEnable = 1'b0;
                        xmClear  = 1'b1;
                        md_cnt_d = md_cnt_q + MD_CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= IDLE;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

`ifdef PIPE_HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles in which the PC was held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pcEnable && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (clear)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stallCnt = stall_cnt_q;
`endif

endmodule
